// File: rtl/ps2_keycode_hub.sv
// ---------------------------------------------------------------------------
// ps2_keycode_hub
//   PS/2 keyboard front-end. It oversamples the raw PS/2 clock and data pins on
//   the system clock and decodes 11-bit frames. E0 (extended) and F0 (break)
//   prefixes are stripped. The block keeps a DEPTH-entry history of make codes
//   and watches for a two-key make sequence that toggles the display/FSM mode.
//
//   Optional build macro: PS2_PARITY_CHECK_EN
//     defined   -> a byte is rejected (frame_err) unless data+parity is odd
//     undefined -> the parity bit is captured but ignored
//
// Ports
//   clk        in   system clock (50 MHz)
//   reset      in   asynchronous, active-high reset
//   ps_clk     in   raw PS/2 clock pin (asynchronous)
//   ps_data    in   raw PS/2 data pin (asynchronous)
//   code_valid out  1-cycle pulse, code/code_ext/code_brk valid
//   code       out  scan code with prefixes removed (held until next pulse)
//   code_ext   out  code was preceded by E0
//   code_brk   out  code was preceded by F0
//   hist       out  make-code history, [7:0] newest
//   seq_hit    out  1-cycle pulse on SEQ_FIRST -> SEQ_SECOND consecutive makes
//   mode_fsm   out  level, 0 = hex display mode, 1 = FSM mode
//   frame_err  out  1-cycle pulse, frame aborted (timeout) or rejected
// ---------------------------------------------------------------------------
module ps2_keycode_hub #(
   parameter int         DEPTH          = 2,
   parameter int         TIMEOUT_CYCLES = 50000,
   parameter logic [7:0] SEQ_FIRST      = 8'h1C,
   parameter logic [7:0] SEQ_SECOND     = 8'h1B
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ps_clk,
   input  logic                 ps_data,
   output logic                 code_valid,
   output logic [7:0]           code,
   output logic                 code_ext,
   output logic                 code_brk,
   output logic [8*DEPTH-1:0]   hist,
   output logic                 seq_hit,
   output logic                 mode_fsm,
   output logic                 frame_err
);

   localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   state_t        state;
   logic [1:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          clk_prev;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par_bit;
   logic [TW-1:0] tcnt;
   logic          ext_pend;
   logic          brk_pend;
   logic          fall;
   logic          din;
   logic          par_ok;

   // Synchronisers reset to 1 (idle bus level) so that leaving reset cannot
   // look like a falling edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], ps_clk};
         data_sync <= {data_sync[0], ps_data};
         clk_prev  <= clk_sync[1];
      end
   end

   assign fall = clk_prev & ~clk_sync[1];
   assign din  = data_sync[1];

`ifdef PS2_PARITY_CHECK_EN
   assign par_ok = ^{shreg, par_bit};
`else
   // The parity bit is still captured, but it never blocks a byte.
   assign par_ok = par_bit | 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         tcnt       <= '0;
         ext_pend   <= 1'b0;
         brk_pend   <= 1'b0;
         code_valid <= 1'b0;
         code       <= '0;
         code_ext   <= 1'b0;
         code_brk   <= 1'b0;
         hist       <= '0;
         seq_hit    <= 1'b0;
         mode_fsm   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         code_valid <= 1'b0;
         seq_hit    <= 1'b0;
         frame_err  <= 1'b0;

         if (state == S_IDLE) begin
            tcnt <= '0;
            if (fall && !din) begin
               state   <= S_DATA;
               bit_cnt <= '0;
            end
         end else if (fall) begin
            // An edge always wins over a timeout in the same cycle.
            tcnt <= '0;
            case (state)
               S_DATA: begin
                  shreg   <= {din, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7)
                     state <= S_PARITY;
               end
               S_PARITY: begin
                  par_bit <= din;
                  state   <= S_STOP;
               end
               default: begin
                  state <= S_IDLE;
                  if (!din || !par_ok) begin
                     frame_err <= 1'b1;
                     ext_pend  <= 1'b0;
                     brk_pend  <= 1'b0;
                  end else if (shreg == 8'hE0) begin
                     ext_pend <= 1'b1;
                  end else if (shreg == 8'hF0) begin
                     brk_pend <= 1'b1;
                  end else begin
                     code_valid <= 1'b1;
                     code       <= shreg;
                     code_ext   <= ext_pend;
                     code_brk   <= brk_pend;
                     ext_pend   <= 1'b0;
                     brk_pend   <= 1'b0;
                     // Only makes (extended or not) enter the history; the
                     // sequence compare uses the newest entry before the shift.
                     if (!brk_pend) begin
                        hist <= {hist[8*DEPTH-9:0], shreg};
                        if (shreg == SEQ_SECOND && hist[7:0] == SEQ_FIRST) begin
                           seq_hit  <= 1'b1;
                           mode_fsm <= ~mode_fsm;
                        end
                     end
                  end
               end
            endcase
         end else if (tcnt == T_LAST) begin
            state     <= S_IDLE;
            tcnt      <= '0;
            frame_err <= 1'b1;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
         end else begin
            tcnt <= tcnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ps2_keycode_hub.sv
module tb_ps2_keycode_hub;

   localparam int TMO  = 300;
   localparam int HALF = 20;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ps_clk = 1'b1;
   logic        ps_data = 1'b1;
   logic        code_valid;
   logic [7:0]  code;
   logic        code_ext;
   logic        code_brk;
   logic [15:0] hist;
   logic        seq_hit;
   logic        mode_fsm;
   logic        frame_err;

   ps2_keycode_hub #(
      .DEPTH(2), .TIMEOUT_CYCLES(TMO), .SEQ_FIRST(8'h1C), .SEQ_SECOND(8'h1B)
   ) dut (
      .clk(clk), .reset(reset), .ps_clk(ps_clk), .ps_data(ps_data),
      .code_valid(code_valid), .code(code), .code_ext(code_ext),
      .code_brk(code_brk), .hist(hist), .seq_hit(seq_hit),
      .mode_fsm(mode_fsm), .frame_err(frame_err)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic [7:0]  b;
      logic        bad_par;
      logic        cv;
      logic [7:0]  code;
      logic        ext;
      logic        brk;
      logic        seq;
      logic        mode;
      logic [15:0] hist;
      logic        err;
   } vec_t;

   typedef struct {
      logic [7:0] code;
      logic       ext;
      logic       brk;
   } exp_t;

   vec_t vecs[13];
   exp_t sbq[$];
   int   tests = 0;
   int   fails = 0;
   int   cv_cnt = 0;
   int   seq_cnt = 0;
   int   err_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every code_valid pulse.
   always @(negedge clk) begin
      if (!reset) begin
         if (code_valid) begin
            cv_cnt++;
            if (sbq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_code_valid: got code %0h expected none", code);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               check("code", {24'd0, code}, {24'd0, e.code});
               check("code_ext", {31'd0, code_ext}, {31'd0, e.ext});
               check("code_brk", {31'd0, code_brk}, {31'd0, e.brk});
            end
         end
         if (seq_hit) seq_cnt++;
         if (frame_err) err_cnt++;
         if (code_valid && frame_err)
            check("cv_err_exclusive", 32'd1, 32'd0);
      end
   end

   task automatic ps_bit(input logic v);
      ps_data = v;
      repeat (HALF) @(posedge clk);
      ps_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps_clk = 1'b1;
   endtask

   // nbits < 11 sends a truncated frame (start bit first).
   task automatic send_frame(input logic [7:0] b, input logic bad_par,
                             input logic bad_stop, input int nbits);
      logic [10:0] f;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) ps_bit(f[i]);
      ps_data = 1'b1;
      repeat (HALF) @(posedge clk);
   endtask

   task automatic push(input logic [7:0] c, input logic e, input logic k);
      exp_t x;
      x.code = c; x.ext = e; x.brk = k;
      sbq.push_back(x);
   endtask

   initial begin
      int c0, s0, e0;
      vecs[0]  = '{8'h1C, 0, 1, 8'h1C, 0, 0, 0, 0, 16'h001C, 0};
      vecs[1]  = '{8'hE0, 0, 0, 8'h00, 0, 0, 0, 0, 16'h001C, 0};
      vecs[2]  = '{8'hF0, 0, 0, 8'h00, 0, 0, 0, 0, 16'h001C, 0};
      vecs[3]  = '{8'h75, 0, 1, 8'h75, 1, 1, 0, 0, 16'h001C, 0};
      vecs[4]  = '{8'h1B, 0, 1, 8'h1B, 0, 0, 1, 1, 16'h1C1B, 0};
      vecs[5]  = '{8'h1C, 0, 1, 8'h1C, 0, 0, 0, 1, 16'h1B1C, 0};
      vecs[6]  = '{8'h1B, 0, 1, 8'h1B, 0, 0, 1, 0, 16'h1C1B, 0};
      vecs[7]  = '{8'hF0, 0, 0, 8'h00, 0, 0, 0, 0, 16'h1C1B, 0};
      vecs[8]  = '{8'h1C, 0, 1, 8'h1C, 0, 1, 0, 0, 16'h1C1B, 0};
      vecs[9]  = '{8'h1B, 0, 1, 8'h1B, 0, 0, 0, 0, 16'h1B1B, 0};
      vecs[10] = '{8'hE0, 0, 0, 8'h00, 0, 0, 0, 0, 16'h1B1B, 0};
      vecs[11] = '{8'h2A, 0, 1, 8'h2A, 1, 0, 0, 0, 16'h1B2A, 0};
`ifdef PS2_PARITY_CHECK_EN
      vecs[12] = '{8'h1C, 1, 0, 8'h00, 0, 0, 0, 0, 16'h1B2A, 1};
`else
      vecs[12] = '{8'h1C, 1, 1, 8'h1C, 0, 0, 0, 0, 16'h2A1C, 0};
`endif

      // Reset state
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {5'd0, code_valid, code, code_ext, code_brk, hist, seq_hit, mode_fsm, frame_err},
            32'd0);
      reset = 1'b0;
      repeat (5) @(posedge clk);

      // Table-driven frames
      for (int i = 0; i < 13; i++) begin
         c0 = cv_cnt; s0 = seq_cnt; e0 = err_cnt;
         if (vecs[i].cv) push(vecs[i].code, vecs[i].ext, vecs[i].brk);
         send_frame(vecs[i].b, vecs[i].bad_par, 1'b0, 11);
         repeat (10) @(posedge clk);
         @(negedge clk);
         check($sformatf("v%0d_cv_count", i), cv_cnt - c0, {31'd0, vecs[i].cv});
         check($sformatf("v%0d_seq_count", i), seq_cnt - s0, {31'd0, vecs[i].seq});
         check($sformatf("v%0d_err_count", i), err_cnt - e0, {31'd0, vecs[i].err});
         check($sformatf("v%0d_hist", i), {16'd0, hist}, {16'd0, vecs[i].hist});
         check($sformatf("v%0d_mode", i), {31'd0, mode_fsm}, {31'd0, vecs[i].mode});
         check($sformatf("v%0d_sb_empty", i), sbq.size(), 0);
      end

      // Timeout: start bit + 4 data bits, then the clock stops
      c0 = cv_cnt; e0 = err_cnt;
      send_frame(8'h2A, 1'b0, 1'b0, 5);
      repeat (TMO + 50) @(posedge clk);
      @(negedge clk);
      check("timeout_err", err_cnt - e0, 1);
      check("timeout_no_cv", cv_cnt - c0, 0);
      push(8'h2A, 1'b0, 1'b0);
      send_frame(8'h2A, 1'b0, 1'b0, 11);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("after_timeout_sb", sbq.size(), 0);
      check("after_timeout_hist0", {24'd0, hist[7:0]}, 32'h2A);

      // Bad stop bit clears a pending E0
      c0 = cv_cnt; e0 = err_cnt;
      send_frame(8'hE0, 1'b0, 1'b0, 11);
      send_frame(8'h55, 1'b0, 1'b1, 11);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("bad_stop_err", err_cnt - e0, 1);
      check("bad_stop_no_cv", cv_cnt - c0, 0);
      push(8'h6B, 1'b0, 1'b0);
      send_frame(8'h6B, 1'b0, 1'b0, 11);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("after_err_sb", sbq.size(), 0);

      // Reset mid-frame after E0
      send_frame(8'hE0, 1'b0, 1'b0, 11);
      send_frame(8'h33, 1'b0, 1'b0, 5);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("mid_reset_outputs", {5'd0, code_valid, code, code_ext, code_brk, hist, seq_hit, mode_fsm, frame_err},
            32'd0);
      ps_clk = 1'b1; ps_data = 1'b1;
      repeat (5) @(posedge clk);
      reset = 1'b0;
      repeat (5) @(posedge clk);
      c0 = cv_cnt;
      push(8'h6B, 1'b0, 1'b0);
      send_frame(8'h6B, 1'b0, 1'b0, 11);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("post_reset_cv", cv_cnt - c0, 1);
      check("post_reset_sb", sbq.size(), 0);
      check("post_reset_hist", {16'd0, hist}, 32'h006B);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
